// File: rtl/apb_master_bridge.sv
// APB3 initiator bridge: accepts one command at a time on a valid/ready stream,
// runs it as a SETUP + ACCESS transfer and holds the response until consumed.
// Each ACCESS phase is bounded by TIMEOUT wait states (0 disables the bound).
module apb_master_bridge #(
    parameter int ADDR_W  = 32,
    parameter int DATA_W  = 32,
    parameter int TIMEOUT = 256
) (
    input  logic              PCLK,
    input  logic              PRESET,
    input  logic              cmd_valid,
    output logic              cmd_ready,
    input  logic              cmd_write,
    input  logic [ADDR_W-1:0] cmd_addr,
    input  logic [DATA_W-1:0] cmd_wdata,
    output logic              rsp_valid,
    input  logic              rsp_ready,
    output logic [DATA_W-1:0] rsp_rdata,
    output logic              rsp_err,
    output logic              rsp_timeout,
    output logic              busy,
    output logic              PSEL,
    output logic              PENABLE,
    output logic              PWRITE,
    output logic [ADDR_W-1:0] PADDR,
    output logic [DATA_W-1:0] PWDATA,
    input  logic [DATA_W-1:0] PRDATA,
    input  logic              PREADY,
    input  logic              PSLVERR
);

    typedef enum logic [1:0] {
        IDLE,
        SETUP,
        ACCESS,
        RESP
    } state_t;

    // Counter must hold TIMEOUT-1; with the bound disabled a single bit is enough
    // because it only saturates and is never compared.
    localparam int CNT_W = (TIMEOUT > 0) ? $clog2(TIMEOUT + 1) : 1;
    localparam logic [CNT_W-1:0] WAIT_LAST = (TIMEOUT > 0) ? CNT_W'(TIMEOUT - 1) : '0;

    state_t           state;
    logic [CNT_W-1:0] wait_cnt;

    assign cmd_ready = (state == IDLE) && !PRESET;
    assign busy      = (state != IDLE);

    // Transfer sequencer: all APB and response outputs are registered here.
    always_ff @(posedge PCLK) begin
        if (PRESET) begin
            state       <= IDLE;
            wait_cnt    <= '0;
            PSEL        <= 1'b0;
            PENABLE     <= 1'b0;
            PWRITE      <= 1'b0;
            PADDR       <= '0;
            PWDATA      <= '0;
            rsp_valid   <= 1'b0;
            rsp_rdata   <= '0;
            rsp_err     <= 1'b0;
            rsp_timeout <= 1'b0;
        end else begin
            case (state)
                IDLE: begin
                    if (cmd_valid && cmd_ready) begin
                        PWRITE <= cmd_write;
                        PADDR  <= cmd_addr;
                        PWDATA <= cmd_write ? cmd_wdata : '0;
                        PSEL   <= 1'b1;
                        state  <= SETUP;
                    end
                end
                SETUP: begin
                    PENABLE  <= 1'b1;
                    wait_cnt <= '0;
                    state    <= ACCESS;
                end
                ACCESS: begin
                    if (PREADY) begin
                        rsp_rdata   <= PWRITE ? '0 : PRDATA;
                        rsp_err     <= PSLVERR;
                        rsp_timeout <= 1'b0;
                        rsp_valid   <= 1'b1;
                        PSEL        <= 1'b0;
                        PENABLE     <= 1'b0;
                        state       <= RESP;
                    end else if ((TIMEOUT != 0) && (wait_cnt == WAIT_LAST)) begin
                        rsp_rdata   <= '0;
                        rsp_err     <= 1'b1;
                        rsp_timeout <= 1'b1;
                        rsp_valid   <= 1'b1;
                        PSEL        <= 1'b0;
                        PENABLE     <= 1'b0;
                        state       <= RESP;
                    end else if (wait_cnt != '1) begin
                        wait_cnt <= wait_cnt + 1'b1;
                    end
                end
                RESP: begin
                    if (rsp_ready) begin
                        rsp_valid <= 1'b0;
                        state     <= IDLE;
                    end
                end
                default: begin
                    state <= IDLE;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_apb_master_bridge.sv
// Testbench for apb_master_bridge: directed scenarios plus randomized transfers
// checked against a transaction-level model of the expected APB behaviour.
module tb_apb_master_bridge;

    localparam int TO = 8;

    logic        PCLK = 1'b0;
    logic        PRESET = 1'b1;
    logic        cmd_valid = 1'b0;
    logic        cmd_valid0 = 1'b0;
    logic        cmd_write = 1'b0;
    logic [31:0] cmd_addr = '0;
    logic [31:0] cmd_wdata = '0;
    logic        rsp_ready = 1'b0;
    logic [31:0] PRDATA = '0;
    logic        PREADY = 1'b0;
    logic        PSLVERR = 1'b0;
    logic        PREADY0 = 1'b0;

    logic        cmd_ready, rsp_valid, rsp_err, rsp_timeout, busy;
    logic        PSEL, PENABLE, PWRITE;
    logic [31:0] rsp_rdata, PADDR, PWDATA;

    logic        cmd_ready0, rsp_valid0, rsp_err0, rsp_timeout0, busy0;
    logic        PSEL0, PENABLE0, PWRITE0;
    logic [31:0] rsp_rdata0, PADDR0, PWDATA0;

    int checks = 0;
    int errors = 0;

    apb_master_bridge #(.ADDR_W(32), .DATA_W(32), .TIMEOUT(TO)) dut (
        .PCLK(PCLK), .PRESET(PRESET),
        .cmd_valid(cmd_valid), .cmd_ready(cmd_ready), .cmd_write(cmd_write),
        .cmd_addr(cmd_addr), .cmd_wdata(cmd_wdata),
        .rsp_valid(rsp_valid), .rsp_ready(rsp_ready), .rsp_rdata(rsp_rdata),
        .rsp_err(rsp_err), .rsp_timeout(rsp_timeout), .busy(busy),
        .PSEL(PSEL), .PENABLE(PENABLE), .PWRITE(PWRITE), .PADDR(PADDR),
        .PWDATA(PWDATA), .PRDATA(PRDATA), .PREADY(PREADY), .PSLVERR(PSLVERR)
    );

    apb_master_bridge #(.ADDR_W(32), .DATA_W(32), .TIMEOUT(0)) dut0 (
        .PCLK(PCLK), .PRESET(PRESET),
        .cmd_valid(cmd_valid0), .cmd_ready(cmd_ready0), .cmd_write(cmd_write),
        .cmd_addr(cmd_addr), .cmd_wdata(cmd_wdata),
        .rsp_valid(rsp_valid0), .rsp_ready(rsp_ready), .rsp_rdata(rsp_rdata0),
        .rsp_err(rsp_err0), .rsp_timeout(rsp_timeout0), .busy(busy0),
        .PSEL(PSEL0), .PENABLE(PENABLE0), .PWRITE(PWRITE0), .PADDR(PADDR0),
        .PWDATA(PWDATA0), .PRDATA(PRDATA), .PREADY(PREADY0), .PSLVERR(PSLVERR)
    );

    // Free-running clock, 10 time units per cycle.
    always #5 PCLK = ~PCLK;

    task automatic checkOutput(input string tag, input logic [127:0] obs, input logic [127:0] exp);
        checks++;
        assert (obs === exp)
        else begin
            errors++;
            $error("[TB] FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    // One complete transfer: the slave inserts 'waits' wait states, the consumer
    // stalls the response for 'rspDelay' cycles. Expectations come from the
    // transaction rules: timeout if waits reach the bound, else a normal completion.
    task automatic applyStimulus(input bit wr, input logic [31:0] addr, input logic [31:0] wdata,
                                 input int waits, input logic [31:0] rdata, input bit slverr,
                                 input int rspDelay);
        int          acc;
        bit          done;
        bit          expTo;
        int          expAcc;
        logic [31:0] expRdata;
        logic [31:0] expWdata;
        bit          expErr;
        expTo    = (TO != 0) && (waits >= TO);
        expAcc   = expTo ? TO : waits + 1;
        expRdata = (expTo || wr) ? 32'h0 : rdata;
        expErr   = expTo || slverr;
        expWdata = wr ? wdata : 32'h0;

        @(negedge PCLK);
        cmd_valid = 1'b1;
        cmd_write = wr;
        cmd_addr  = addr;
        cmd_wdata = wdata;
        PRDATA    = rdata;
        PSLVERR   = slverr;
        PREADY    = 1'b0;
        checkOutput("cmd_ready_idle", cmd_ready, 1);

        @(negedge PCLK);
        cmd_valid = 1'b0;
        cmd_addr  = $urandom;
        cmd_wdata = $urandom;
        checkOutput("setup_psel_penable", {PSEL, PENABLE}, 2'b10);
        checkOutput("setup_fields", {PWRITE, PADDR, PWDATA}, {wr, addr, expWdata});
        checkOutput("setup_busy_ready", {busy, cmd_ready}, 2'b10);

        acc  = 0;
        done = 1'b0;
        for (int c = 0; c < 64 && !done; c++) begin
            @(negedge PCLK);
            if (rsp_valid) begin
                done = 1'b1;
            end else if (PSEL && PENABLE) begin
                acc++;
                checkOutput("access_hold", {PWRITE, PADDR, PWDATA}, {wr, addr, expWdata});
                PREADY = (acc == waits + 1);
            end
        end
        PREADY = 1'b0;
        checkOutput("rsp_seen", done, 1);
        checkOutput("access_cycles", acc, expAcc);
        checkOutput("resp_apb_idle", {PSEL, PENABLE, cmd_ready, busy}, 4'b0001);
        checkOutput("resp_fields", {rsp_rdata, rsp_err, rsp_timeout}, {expRdata, expErr, expTo});
        checkOutput("resp_keep_fields", {PWRITE, PADDR, PWDATA}, {wr, addr, expWdata});

        for (int d = 0; d < rspDelay; d++) begin
            @(negedge PCLK);
            checkOutput("resp_stall", {rsp_valid, cmd_ready, rsp_rdata, rsp_err, rsp_timeout},
                        {1'b1, 1'b0, expRdata, expErr, expTo});
        end
        rsp_ready = 1'b1;
        @(negedge PCLK);
        rsp_ready = 1'b0;
        checkOutput("resp_taken", {rsp_valid, busy, cmd_ready}, 3'b001);
    endtask

    initial begin
        int riseA;
        int riseB;
        int rspSeen;

        $display("[TB] reset");
        repeat (3) @(negedge PCLK);
        checkOutput("reset_ctrl", {PSEL, PENABLE, PWRITE, rsp_valid, rsp_err, rsp_timeout, busy, cmd_ready}, 8'h00);
        checkOutput("reset_data", {PADDR, PWDATA, rsp_rdata}, 96'h0);
        PRESET = 1'b0;
        @(negedge PCLK);
        checkOutput("ready_after_reset", cmd_ready, 1);

        $display("[TB] write 0x18 zero wait");
        applyStimulus(1'b1, 32'h18, 32'h0000_0800, 0, 32'hDEAD_BEEF, 1'b0, 0);

        $display("[TB] read 0x04");
        applyStimulus(1'b0, 32'h04, 32'h1234_5678, 0, 32'h0000_0005, 1'b0, 0);

        $display("[TB] back-to-back reads");
        @(negedge PCLK);
        cmd_valid = 1'b1;
        cmd_write = 1'b0;
        cmd_addr  = 32'h04;
        PREADY    = 1'b1;
        PRDATA    = 32'h5;
        PSLVERR   = 1'b0;
        rsp_ready = 1'b1;
        riseA     = -1;
        riseB     = -1;
        rspSeen   = 0;
        for (int c = 0; c < 14; c++) begin
            @(negedge PCLK);
            if (PSEL && !PENABLE) begin
                if (riseA < 0) begin
                    riseA    = c;
                    cmd_addr = 32'h0C;
                end else if (riseB < 0) begin
                    riseB     = c;
                    cmd_valid = 1'b0;
                    checkOutput("b2b_second_addr", PADDR, 32'h0C);
                end
            end
            if (rsp_valid) begin
                rspSeen++;
                checkOutput("b2b_rdata", rsp_rdata, 32'h5);
            end
        end
        checkOutput("b2b_psel_spacing", riseB - riseA, 4);
        checkOutput("b2b_rsp_count", rspSeen, 2);
        cmd_valid = 1'b0;
        rsp_ready = 1'b0;
        PREADY    = 1'b0;
        @(negedge PCLK);
        checkOutput("b2b_idle", {busy, cmd_ready}, 2'b01);

        $display("[TB] read 0x0C with 3 wait states");
        applyStimulus(1'b0, 32'h0C, 32'h0, 3, 32'h0000_00A5, 1'b0, 1);

        $display("[TB] timeout");
        applyStimulus(1'b0, 32'h10, 32'h0, 40, 32'h5A5A_5A5A, 1'b0, 2);
        applyStimulus(1'b0, 32'h14, 32'h0, TO - 1, 32'h0000_0077, 1'b0, 0);

        $display("[TB] slave error with stalled consumer");
        applyStimulus(1'b1, 32'h20, 32'hCAFE_0001, 0, 32'h0, 1'b1, 5);

        $display("[TB] randomized transfers");
        for (int n = 0; n < 16; n++) begin
            applyStimulus(1'($urandom_range(0, 1)), $urandom & 32'hFFFF_FFFC, $urandom,
                          $urandom_range(0, 11), $urandom, 1'($urandom_range(0, 1)),
                          $urandom_range(0, 3));
        end

        $display("[TB] unbounded wait instance");
        @(negedge PCLK);
        cmd_valid0 = 1'b1;
        cmd_write  = 1'b0;
        cmd_addr   = 32'h3C;
        @(negedge PCLK);
        cmd_valid0 = 1'b0;
        checkOutput("nobound_setup", {PSEL0, PENABLE0, PADDR0}, {2'b10, 32'h3C});
        repeat (1000) @(negedge PCLK);
        checkOutput("nobound_waiting", {PSEL0, PENABLE0, rsp_valid0, busy0}, 4'b1101);

        $display("[TB] reset during access");
        @(negedge PCLK);
        cmd_valid = 1'b1;
        cmd_write = 1'b0;
        cmd_addr  = 32'h30;
        PREADY    = 1'b0;
        @(negedge PCLK);
        cmd_valid = 1'b0;
        @(negedge PCLK);
        checkOutput("pre_reset_access", {PSEL, PENABLE}, 2'b11);
        PRESET = 1'b1;
        @(posedge PCLK);
        #1;
        checkOutput("reset_mid_xfer", {PSEL, PENABLE, rsp_valid, busy, cmd_ready}, 5'b00000);
        @(negedge PCLK);
        PRESET = 1'b0;
        applyStimulus(1'b1, 32'h28, 32'h0000_00C3, 1, 32'h0, 1'b0, 0);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
